// File: rtl/debug_display_ctrl.sv
// Debug display controller: per-channel 32-bit shadow registers shown on seven-segment digits,
// debounced page key, sticky debug LEDs. Optional macro DEBUG_DISPLAY_BLANK_EN enables leading-zero blanking.
module debug_display_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int DIGITS       = 8,
    parameter int LED_W        = 18,
    parameter int FLAG_W       = 16,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CH*32-1:0]                      ch_data,
    input  logic [NUM_CH-1:0]                         ch_valid,
    input  logic                                      freeze,
    input  logic                                      page_key_n,
    input  logic [FLAG_W-1:0]                         debug_flag,
    input  logic                                      debug_flag_valid,
    input  logic                                      led_clr,
    output logic [DIGITS*7-1:0]                       hex_n,
    output logic [LED_W-1:0]                          led,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] page
);

    localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic                    r_rst_q;
    logic                    r_key_meta;
    logic                    r_key_sync;
    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [PAGE_W-1:0]       r_page;
    logic [31:0]             r_shadow [NUM_CH];
    logic [DIGITS*7-1:0]     r_hex;
    logic [LED_W-1:0]        r_led;

    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_sat;
    logic                    w_page_inc;
    logic [31:0]             w_sel_word;
    logic [DIGITS*7-1:0]     w_hex_nxt;
    logic [31:0]             w_led_idx;
    logic [LED_W-1:0]        w_led_nxt;
`ifdef DEBUG_DISPLAY_BLANK_EN
    logic                    w_lead;
`endif

    // Reset release is retimed so the whole block leaves reset on one clean edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_q <= 1'b0;
        end else begin
            r_rst_q <= 1'b1;
        end
    end

    // Two-flop synchroniser for the raw pushbutton (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= page_key_n;
            r_key_sync <= r_key_meta;
        end
    end

    assign w_cnt_sat = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

    // Debounce FSM next-state; a page step happens only on PRESS_WAIT -> PRESSED
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_page_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_key_sync) begin
                    w_state_nxt = S_PRESS_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRESS_WAIT: begin
                if (r_key_sync) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                    w_page_inc  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
            end
            S_PRESSED: begin
                w_cnt_nxt = '0;
                if (r_key_sync) begin
                    w_state_nxt = S_RELEASE_WAIT;
                end else begin
                    w_state_nxt = S_PRESSED;
                end
            end
            S_RELEASE_WAIT: begin
                if (!r_key_sync) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Debounce state, counter and page register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_page  <= '0;
        end else if (!r_rst_q) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_page  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_page_inc) begin
                r_page <= (r_page == PAGE_LAST) ? '0 : (r_page + PAGE_W'(1));
            end else begin
                r_page <= r_page;
            end
        end
    end

    // Channel shadow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= 32'h0;
        end else if (!r_rst_q) begin
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= 32'h0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !freeze) begin
                    r_shadow[i] <= ch_data[32*i +: 32];
                end else begin
                    r_shadow[i] <= r_shadow[i];
                end
            end
        end
    end

    assign w_sel_word = r_shadow[r_page];

    // Segment pattern for the selected word, scanned from the top digit down
    always_comb begin
        w_hex_nxt = '0;
`ifdef DEBUG_DISPLAY_BLANK_EN
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if ((w_sel_word[4*k +: 4] != 4'h0) || (k == 0)) begin
                w_lead = 1'b0;
            end else begin
                w_lead = w_lead;
            end
            w_hex_nxt[7*k +: 7] = w_lead ? SEG_BLANK : seg_encode(w_sel_word[4*k +: 4]);
        end
`else
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_hex_nxt[7*k +: 7] = seg_encode(w_sel_word[4*k +: 4]);
        end
`endif
    end

    // Registered segment outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex <= {DIGITS{SEG_ZERO}};
        end else if (!r_rst_q) begin
            r_hex <= {DIGITS{SEG_ZERO}};
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    // Out-of-range flags collapse onto the top LED as an overflow marker
    always_comb begin
        w_led_idx = (32'(debug_flag) < 32'(LED_W)) ? 32'(debug_flag) : 32'(LED_W - 1);
        w_led_nxt = led_clr ? '0 : r_led;
        if (debug_flag_valid) begin
            for (int i = 0; i < LED_W; i++) begin
                if (w_led_idx == 32'(i)) begin
                    w_led_nxt[i] = 1'b1;
                end else begin
                    w_led_nxt[i] = w_led_nxt[i];
                end
            end
        end else begin
            w_led_nxt = w_led_nxt;
        end
    end

    // Sticky LED register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
        end else if (!r_rst_q) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign hex_n = r_hex;
    assign led   = r_led;
    assign page  = r_page;

endmodule

// File: doc/debug_display_ctrl.md
DEBUG_DISPLAY_CTRL -- requirements
Module: debug_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of 32-bit display channels (pages), range 1..16.
REQ-002 SHALL have parameter DIGITS, default 8: number of seven-segment digits, range 1..8.
REQ-003 SHALL have parameter LED_W, default 18: width of the sticky LED vector.
REQ-004 SHALL have parameter FLAG_W, default 16: width of the debug flag index.
REQ-005 SHALL have parameter DEBOUNCE_CYC, default 500000: number of stable cycles needed to accept a key edge.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 ch_data  in  NUM_CH*32  channel i is at [32i+31:32i].
REQ-009 ch_valid  in  NUM_CH  bit i high captures channel i.
REQ-010 freeze  in  1  high blocks all captures.
REQ-011 page_key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
REQ-012 debug_flag  in  FLAG_W  LED index to set.
REQ-013 debug_flag_valid  in  1  qualifies debug_flag.
REQ-014 led_clr  in  1  synchronous clear of the LED vector.
REQ-015 hex_n  out  DIGITS*7  active-low segments; digit k is at [7k+6:7k] and shows nibble k of the selected word.
REQ-016 led  out  LED_W  sticky debug LEDs.
REQ-017 page  out  max(1,$clog2(NUM_CH))  currently selected channel.

Function
REQ-018 Each channel SHALL hold a 32-bit shadow register, loaded from ch_data on the cycle after ch_valid[i]=1 and freeze=0; otherwise it holds.
REQ-019 Simultaneous ch_valid bits SHALL update all asserted channels in the same cycle.
REQ-020 hex_n SHALL be registered, with 1-cycle latency from the selected shadow register or from a page change.
REQ-021 Segment encoding SHALL be the standard active-low hex font; examples: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.
REQ-022 page_key_n SHALL pass through a 2-flop synchroniser and then a debounce FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-023 IDLE SHALL go to PRESS_WAIT when the synchronised key is 0, clearing the counter.
REQ-024 PRESS_WAIT SHALL return to IDLE if the key returns to 1; it SHALL go to PRESSED after DEBOUNCE_CYC consecutive cycles of 0.
REQ-025 Entry to PRESSED SHALL increment page by exactly 1, wrapping from NUM_CH-1 to 0; NUM_CH=1 keeps page at 0.
REQ-026 PRESSED SHALL go to RELEASE_WAIT when the key is 1; RELEASE_WAIT SHALL go to IDLE after DEBOUNCE_CYC consecutive cycles of 1 and back to PRESSED on any 0.
REQ-027 Holding the key SHALL produce exactly one page increment.
REQ-028 When debug_flag_valid=1, led SHALL set bit debug_flag if debug_flag<LED_W, otherwise bit LED_W-1 (overflow indicator).
REQ-029 Set LED bits SHALL stay set until led_clr or reset.
REQ-030 When led_clr and debug_flag_valid are both asserted in the same cycle, led SHALL become only the newly set bit.
REQ-031 The debounce counter SHALL be $clog2(DEBOUNCE_CYC+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-032 Asserting reset SHALL immediately clear all shadow registers, set page=0, set the FSM to IDLE, set the counter to 0, set led=0 and set hex_n to the code for 0 on every digit.
REQ-033 Reset asserted mid-debounce SHALL discard the pending press; no page increment SHALL occur after release.
REQ-034 Deassertion SHALL be used synchronised; the first capture SHALL be allowed on the second clk edge after deassertion.

Configuration
REQ-035 Macro DEBUG_DISPLAY_BLANK_EN, when defined, SHALL enable leading-zero blanking: every digit above the most significant non-zero nibble drives 7'h7F, and digit 0 always shows its value.
REQ-036 Without DEBUG_DISPLAY_BLANK_EN, all DIGITS digits SHALL always be displayed, including leading zeros.

Verification (NUM_CH=4, DIGITS=8, LED_W=18, DEBOUNCE_CYC=4)
REQ-037 ch_valid=4'b0001 with channel 0 data 32'h1234ABCD, page 0 -> 1 cycle later hex_n digit0=7'h21 (D) and digit7=7'h79 (1).
REQ-038 key held low for 3 cycles and then bouncing high -> page stays 0; key held low for 10 cycles -> page=1 exactly once; four clean presses from page 0 -> page wraps back to 0.
REQ-039 debug_flag=5 with valid, then 20 with valid -> led=18'h20020; next led_clr together with flag 2 -> led=18'h00004.
REQ-040 freeze=1 with ch_valid=4'b1111 and new data -> shadow registers and hex_n unchanged; freeze=0 with ch_valid -> update appears 2 cycles later.
REQ-041 Reset pulsed during PRESS_WAIT, key then released -> page=0, led=0, all digits 7'h40.
REQ-042 With DEBUG_DISPLAY_BLANK_EN, word 32'h000000A0 -> digits 7..2 = 7'h7F, digit1=7'h08 (A), digit0=7'h40 (0); word 0 -> only digit0 lit, showing 7'h40.
